sc_access_ctrl: RTL and testbench
=================================

# sc_access_ctrl

Access controller sitting between the raw button pins and the safe-lock FSM (`sc`). It synchronises and debounces the four buttons into one-cycle press codes and counts digits per attempt. It enforces a lockout after repeated failed attempts and re-locks an open safe after inactivity. All lock-side sequencing (attempt framing, resync, relock) lives here; the lock FSM only compares digits.

## Interface
- `DEBOUNCE_CYCLES`, 4: cycles a button vector must be stable before it is accepted.
- `DIGITS`, 3: presses per code attempt.
- `MAX_FAILS`, 3: failed attempts that trigger lockout.
- `LOCKOUT_CYCLES`, 1000: lockout duration.
- `RELOCK_CYCLES`, 5000: inactivity timeout, used in OPEN and ENTRY.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `btn_raw` in 4: asynchronous button pins.
- `unlocked` in 1: the lock FSM's unlocked output.
- `btn_out` out 4: press code to the lock FSM. Nonzero for exactly one cycle per accepted press, otherwise 0.
- `relock_req` out 1: one-cycle pulse. Wired to the lock FSM's state-only clear, never to its passcode reset.
- `fail_count` out `$clog2(MAX_FAILS+1)`: failed attempts in the current window.
- `alarm` out 1: high throughout LOCKOUT.

## Operation
- Press path:
  - 2-FF synchroniser, then debounce.
  - A press is emitted when the vector is nonzero and unchanged for `DEBOUNCE_CYCLES`. The emitted code is that stable vector.
  - No further press is emitted until the vector has been all-zero for `DEBOUNCE_CYCLES`.
  - A code change while the vector is still nonzero restarts stability counting but does not re-arm the press.
- Controller states: LOCKED, ENTRY, CHECK, OPEN, PROG, LOCKOUT.
  - **LOCKED:**
    - A press is forwarded, digit counter set to 1, go to ENTRY.
    - If `DIGITS`==1, go directly to CHECK.
  - **ENTRY:**
    - Each press is forwarded and increments the digit counter.
    - The `DIGITS`-th press goes to CHECK.
    - No press for `RELOCK_CYCLES`: pulse `relock_req`, clear digits, go to LOCKED. No fail is counted.
  - **CHECK** (one cycle; samples `unlocked`):
    - `unlocked`=1: clear `fail_count`, go to OPEN.
    - Otherwise: increment `fail_count` and pulse `relock_req` to resync the lock to its first digit.
    - If the new count equals `MAX_FAILS`, go to LOCKOUT; else go to LOCKED.
    - A press arriving in CHECK is dropped.
  - **OPEN:**
    - Presses are forwarded; any press restarts the inactivity timer.
    - Timer reaches `RELOCK_CYCLES`: pulse `relock_req`, go to LOCKED.
    - `unlocked` falls with no `relock_req` issued (lock entered programming): go to PROG, digit counter cleared.
  - **PROG:**
    - Forward `DIGITS` presses, then go to LOCKED.
    - No inactivity timeout.
  - **LOCKOUT:**
    - `btn_out` forced to 0; presses are dropped.
    - After `LOCKOUT_CYCLES`, clear `fail_count` and go to LOCKED.
- Simultaneous events:
  - Timer expiry and a press in the same cycle: expiry wins and the press is dropped.
  - Lockout end and a press in the same cycle: the press is dropped.
- Counters saturate; they never wrap.

## Timing
- Reset values: `btn_out`=0, `relock_req`=0, `fail_count`=0, `alarm`=0, state LOCKED, all timers and the digit counter 0.
- Reset mid-operation: everything returns to reset values on the next edge.
  - The debouncer starts in the "held" condition.
  - A button held through reset is not emitted until it has been released and pressed again.
- Latency from a stable `btn_raw` change to `btn_out`: 2 + `DEBOUNCE_CYCLES` cycles.
- Final digit forwarded at cycle t: CHECK is occupied at t+1 and samples `unlocked` there. The registered lock FSM reflects the digit by t+1.
- `relock_req` and `alarm` are registered outputs. `alarm` rises on the LOCKOUT entry edge.
- LOCKOUT lasts exactly `LOCKOUT_CYCLES` cycles.

## Configuration
- `SC_ACCESS_CTRL_RELOCK_EN`:
  - Defined: ENTRY abort and OPEN auto-relock are active, using the `RELOCK_CYCLES` timer.
  - Undefined: the timer logic is removed. ENTRY waits indefinitely and OPEN persists until the lock enters programming. `relock_req` is then issued only from CHECK failures.

## Structure
- Shared package `sc_pkg`: controller state enum and default parameter constants (digit count, fail limit, timeouts).
- Sub-module `sc_btn_debounce`: synchroniser, debounce and press-event generation. Outputs a one-cycle `press` and a 4-bit `code`.
- The controller FSM, timers and counters are in `sc_access_ctrl`.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=2, `LOCKOUT_CYCLES`=20, `RELOCK_CYCLES`=50, with the `sc` lock model attached.
- Correct code 0111, 1101, 1101, each held 5 cycles and released 5 cycles -> three one-cycle `btn_out` pulses; state OPEN; `fail_count`=0.
- Three wrong attempts of 1000 ×3 -> `fail_count` 1, 2, 3, each with a `relock_req` pulse. `alarm` high for exactly 20 cycles; presses during lockout give `btn_out`=0; afterwards `fail_count`=0.
- OPEN with 50 idle cycles -> `relock_req` pulse, lock returns to S0, state LOCKED. With the macro undefined, the controller stays OPEN.
- In OPEN, press 0001, then 0010, 0100, 1000 -> PROG consumes three digits, then LOCKED; the new code 0010, 0100, 1000 unlocks.
- Button bouncing 1,0,1 at single-cycle intervals, then stable 1 -> exactly one `btn_out`=0001. Holding 0011 and then changing to 0001 -> no second pulse.
- `rst` asserted mid-ENTRY with a button held -> all outputs 0 next cycle; no press is emitted until the button is released and re-pressed.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared definitions for the safe-lock access controller: controller state
// encoding, default parameter values and a counter-width helper.
package sc_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_PROG,
    ST_LOCKOUT
  } ctrl_state_e;

  localparam int unsigned SC_DEBOUNCE_CYCLES = 4;
  localparam int unsigned SC_DIGITS          = 3;
  localparam int unsigned SC_MAX_FAILS       = 3;
  localparam int unsigned SC_LOCKOUT_CYCLES  = 1000;
  localparam int unsigned SC_RELOCK_CYCLES   = 5000;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sc_btn_debounce.sv
// Button synchroniser and debouncer: emits a one-cycle press with the stable
// nonzero code, re-armed only after the vector has been all-zero long enough.
module sc_btn_debounce
  import sc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SC_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic       press,
  output logic [3:0] code
);
  localparam int unsigned     CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d, last_q, last_d, code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d, run;
  logic          armed_q, armed_d, press_q, press_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    last_d  = sync2_q;
    // run: consecutive cycles (including this one) the vector has held its value
    if (sync2_q != last_q)       run = CW'(1);
    else if (cnt_q == CNT_MAX)   run = CNT_MAX;
    else                         run = cnt_q + CW'(1);
    cnt_d   = run;
    press_d = armed_q && (run == CNT_MAX) && (sync2_q != '0);
    code_d  = press_d ? sync2_q : '0;
    armed_d = armed_q;
    if (press_d)                                  armed_d = 1'b0;
    else if ((run == CNT_MAX) && (sync2_q == '0)) armed_d = 1'b1;
  end

  // Synchroniser resets to all-ones so the debouncer starts "held".
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      last_q  <= '1;
      cnt_q   <= '0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      code_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
      code_q  <= code_d;
    end
  end

  assign press = press_q;
  assign code  = code_q;

endmodule

// File: rtl/sc_access_ctrl.sv
// Access controller in front of the safe-lock FSM: attempt framing, lockout and
// inactivity relock. Optional feature macro: SC_ACCESS_CTRL_RELOCK_EN.
module sc_access_ctrl
  import sc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = SC_DEBOUNCE_CYCLES,
  parameter int unsigned DIGITS          = SC_DIGITS,
  parameter int unsigned MAX_FAILS       = SC_MAX_FAILS,
  parameter int unsigned LOCKOUT_CYCLES  = SC_LOCKOUT_CYCLES,
  parameter int unsigned RELOCK_CYCLES   = SC_RELOCK_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       btn_raw,
  input  logic                             unlocked,
  output logic [3:0]                       btn_out,
  output logic                             relock_req,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
  output logic                             alarm
);
  localparam int unsigned   FW = $clog2(MAX_FAILS + 1);
  localparam int unsigned   DW = cnt_width(DIGITS);
  // One timer serves both lockout and inactivity; their states never overlap.
  localparam int unsigned   TW = cnt_width((LOCKOUT_CYCLES > RELOCK_CYCLES) ? LOCKOUT_CYCLES
                                                                            : RELOCK_CYCLES);
  localparam logic [DW-1:0] LAST_DIGIT = DW'(DIGITS - 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
  localparam logic [TW-1:0] LOCK_END   = TW'(LOCKOUT_CYCLES - 1);
`ifdef SC_ACCESS_CTRL_RELOCK_EN
  localparam logic [TW-1:0] IDLE_END   = TW'(RELOCK_CYCLES - 1);
`endif

  ctrl_state_e   state_q, state_d;
  logic [DW-1:0] digit_q, digit_d;
  logic [FW-1:0] fail_q, fail_d, fail_inc;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          relock_q, relock_d, alarm_q, alarm_d;
  logic          press, fwd;
  logic [3:0]    code;

  sc_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_raw),
    .press   (press),
    .code    (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOCKED;
      digit_q  <= '0;
      fail_q   <= '0;
      tmr_q    <= '0;
      relock_q <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      digit_q  <= digit_d;
      fail_q   <= fail_d;
      tmr_q    <= tmr_d;
      relock_q <= relock_d;
      alarm_q  <= alarm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    digit_d  = digit_q;
    fail_d   = fail_q;
    tmr_d    = '0;
    relock_d = 1'b0;
    fwd      = 1'b0;
    fail_inc = (fail_q == FAIL_MAX) ? fail_q : fail_q + FW'(1);
    unique case (state_q)
      ST_LOCKED: if (press) begin
        fwd     = 1'b1;
        digit_d = DW'(1);
        state_d = (DIGITS == 1) ? ST_CHECK : ST_ENTRY;
      end
      ST_ENTRY: begin
`ifdef SC_ACCESS_CTRL_RELOCK_EN
        tmr_d = press ? '0 : tmr_q + TW'(1);
        if (tmr_q == IDLE_END) begin
          tmr_d    = '0;
          relock_d = 1'b1;
          digit_d  = '0;
          state_d  = ST_LOCKED;
        end else
`endif
        if (press) begin
          fwd     = 1'b1;
          digit_d = digit_q + DW'(1);
          if (digit_q == LAST_DIGIT) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        digit_d = '0;
        if (unlocked) begin
          fail_d  = '0;
          state_d = ST_OPEN;
        end else begin
          relock_d = 1'b1;
          fail_d   = fail_inc;
          state_d  = (fail_inc == FAIL_MAX) ? ST_LOCKOUT : ST_LOCKED;
        end
      end
      ST_OPEN: begin
`ifdef SC_ACCESS_CTRL_RELOCK_EN
        tmr_d = press ? '0 : tmr_q + TW'(1);
        if (tmr_q == IDLE_END) begin
          tmr_d    = '0;
          relock_d = 1'b1;
          state_d  = ST_LOCKED;
        end else
`endif
        begin
          fwd = press;
          if (!unlocked) begin
            tmr_d   = '0;
            digit_d = '0;
            state_d = ST_PROG;
          end
        end
      end
      ST_PROG: if (press) begin
        fwd = 1'b1;
        if (digit_q == LAST_DIGIT) begin
          digit_d = '0;
          state_d = ST_LOCKED;
        end else begin
          digit_d = digit_q + DW'(1);
        end
      end
      ST_LOCKOUT: begin
        if (tmr_q == LOCK_END) begin
          fail_d  = '0;
          state_d = ST_LOCKED;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = ST_LOCKED;
    endcase
    alarm_d = (state_d == ST_LOCKOUT);
  end

  always_comb begin
    btn_out    = fwd ? code : '0;
    relock_req = relock_q;
    fail_count = fail_q;
    alarm      = alarm_q;
  end

endmodule

// File: tb/tb_sc_access_ctrl.sv
// Bench for sc_access_ctrl with a behavioural safe-lock model attached to
// btn_out / relock_req / unlocked.
module tb_sc_access_ctrl;
  localparam int unsigned DEB = 2, DIG = 3, MAXF = 3, LOCK = 20, RELOCK = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       unlocked;
  logic [3:0] btn_out;
  logic       relock_req;
  logic [1:0] fail_count;
  logic       alarm;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sc_access_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .DIGITS          (DIG),
    .MAX_FAILS       (MAXF),
    .LOCKOUT_CYCLES  (LOCK),
    .RELOCK_CYCLES   (RELOCK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .unlocked   (unlocked),
    .btn_out    (btn_out),
    .relock_req (relock_req),
    .fail_count (fail_count),
    .alarm      (alarm)
  );

  // Lock model: compares digits, unlocks on a full match, 0001 while open
  // enters programming and the next DIG presses become the new code.
  logic [3:0]  lk_pass [DIG];
  int unsigned lk_idx = 0;
  logic        lk_ok = 1'b1, lk_unl = 1'b0, lk_prog = 1'b0;
  assign unlocked = lk_unl;

  always @(posedge clk) begin
    if (rst) begin
      lk_pass[0] <= 4'b0111; lk_pass[1] <= 4'b1101; lk_pass[2] <= 4'b1101;
      lk_idx <= 0; lk_ok <= 1'b1; lk_unl <= 1'b0; lk_prog <= 1'b0;
    end else if (relock_req) begin
      lk_idx <= 0; lk_ok <= 1'b1; lk_unl <= 1'b0; lk_prog <= 1'b0;
    end else if (btn_out != 4'b0000) begin
      if (lk_prog) begin
        lk_pass[lk_idx] <= btn_out;
        if (lk_idx == DIG - 1) begin lk_idx <= 0; lk_prog <= 1'b0; end
        else lk_idx <= lk_idx + 1;
      end else if (lk_unl) begin
        if (btn_out == 4'b0001) begin lk_unl <= 1'b0; lk_prog <= 1'b1; lk_idx <= 0; end
      end else if (lk_idx == DIG - 1) begin
        lk_unl <= lk_ok && (btn_out == lk_pass[lk_idx]);
        lk_idx <= 0; lk_ok <= 1'b1;
      end else begin
        lk_ok  <= lk_ok && (btn_out == lk_pass[lk_idx]);
        lk_idx <= lk_idx + 1;
      end
    end
  end

  // Event counters sampled on the falling edge.
  int unsigned cyc = 0, n_press = 0, n_relock = 0, n_alarm = 0;
  int unsigned last_press_cyc = 0, last_relock_cyc = 0;
  logic [3:0]  last_code = 4'b0000;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (btn_out != 4'b0000) begin
      n_press <= n_press + 1; last_code <= btn_out; last_press_cyc <= cyc;
    end
    if (relock_req) begin n_relock <= n_relock + 1; last_relock_cyc <= cyc; end
    if (alarm) n_alarm <= n_alarm + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_btn(input logic [3:0] c, input int hold, input int rel);
    btn_raw = c;
    tick(hold);
    btn_raw = 4'b0000;
    tick(rel);
  endtask

  task automatic attempt(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    press_btn(a, int'($urandom_range(3, 6)), int'($urandom_range(5, 7)));
    press_btn(b, int'($urandom_range(3, 6)), int'($urandom_range(5, 7)));
    press_btn(c, int'($urandom_range(3, 6)), int'($urandom_range(5, 7)));
  endtask

  logic [3:0]  exp_pass [DIG];
  logic [3:0]  dg [DIG];
  logic        good;
  int          lat;
  int unsigned model_fails, sp, sr, sa;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn_raw = 4'b0000; model_fails = 0;
    exp_pass[0] = 4'b0111; exp_pass[1] = 4'b1101; exp_pass[2] = 4'b1101;
    tick(3);
    chk("rst_btn_out", btn_out, 0);
    chk("rst_relock", relock_req, 0);
    chk("rst_fail", fail_count, 0);
    chk("rst_alarm", alarm, 0);
    rst = 1'b0;
    tick(6);

    // Correct code, with latency on the first digit
    sp = n_press;
    btn_raw = exp_pass[0]; lat = 0;
    while (btn_out == 4'b0000 && lat < 10) begin @(negedge clk); lat++; end
    chk("press_latency", lat, 2 + DEB);
    chk("first_code", btn_out, exp_pass[0]);
    if (lat < 5) tick(5 - lat);
    btn_raw = 4'b0000; tick(5);
    press_btn(exp_pass[1], 5, 5);
    press_btn(exp_pass[2], 5, 5);
    chk("good_press_cnt", n_press - sp, 3);
    chk("good_unlocked", lk_unl, 1);
    chk("good_fail", fail_count, 0);

    // Inactivity in OPEN
    sr = n_relock;
    tick(60);
`ifdef SC_ACCESS_CTRL_RELOCK_EN
    chk("idle_relock_cnt", n_relock - sr, 1);
    chk("idle_relock_time", last_relock_cyc - last_press_cyc, RELOCK + 2);
    chk("idle_lock_closed", lk_unl, 0);
    attempt(exp_pass[0], exp_pass[1], exp_pass[2]);
    chk("reopen_unlocked", lk_unl, 1);
`else
    chk("idle_no_relock", n_relock - sr, 0);
    chk("idle_stays_open", lk_unl, 1);
`endif

    // Programming a new code from OPEN, then restoring the original
    sp = n_press;
    press_btn(4'b0001, 5, 5);
    attempt(4'b0010, 4'b0100, 4'b1000);
    chk("prog_press_cnt", n_press - sp, 4);
    chk("prog_relocked", lk_unl, 0);
    attempt(4'b0010, 4'b0100, 4'b1000);
    chk("newcode_unlocked", lk_unl, 1);
    chk("newcode_fail", fail_count, 0);
    press_btn(4'b0001, 5, 5);
    attempt(exp_pass[0], exp_pass[1], exp_pass[2]);
    chk("restore_locked", lk_unl, 0);

    // Three wrong attempts -> lockout
    for (int k = 1; k <= 3; k++) begin
      sr = n_relock;
      if (k == 3) sa = n_alarm;
      attempt(4'b1000, 4'b1000, 4'b1000);
      chk("wrong_fail_cnt", fail_count, k);
      chk("wrong_relock", n_relock - sr, 1);
    end
    chk("lockout_alarm", alarm, 1);
    sp = n_press;
    press_btn(4'b0010, 5, 5);
    chk("lockout_drop", n_press - sp, 0);
    tick(30);
    chk("lockout_len", n_alarm - sa, LOCK);
    chk("lockout_fail_clr", fail_count, 0);
    chk("lockout_alarm_off", alarm, 0);

    // Randomised attempts against the fail-count rules
    for (int a = 0; a < 8; a++) begin
      good = 1'b1;
      for (int i = 0; i < DIG; i++) begin
        dg[i] = ($urandom_range(0, 2) == 0) ? exp_pass[i] : 4'($urandom_range(1, 15));
        if (dg[i] != exp_pass[i]) good = 1'b0;
      end
      sp = n_press; sr = n_relock; sa = n_alarm;
      attempt(dg[0], dg[1], dg[2]);
      chk("rnd_press_cnt", n_press - sp, 3);
      if (good) begin
        model_fails = 0;
        chk("rnd_unlocked", lk_unl, 1);
        chk("rnd_fail_clr", fail_count, 0);
        press_btn(4'b0001, 5, 5);
        attempt(dg[0], dg[1], dg[2]);
        chk("rnd_relocked", lk_unl, 0);
      end else begin
        model_fails++;
        chk("rnd_locked", lk_unl, 0);
        chk("rnd_relock", n_relock - sr, 1);
        chk("rnd_fail_cnt", fail_count, model_fails);
        if (model_fails == MAXF) begin
          tick(LOCK + 10);
          chk("rnd_lockout_len", n_alarm - sa, LOCK);
          chk("rnd_lockout_clr", fail_count, 0);
          model_fails = 0;
        end
      end
    end
    if (model_fails < 2) begin
      attempt(4'b1000, 4'b1000, 4'b1000);
      model_fails++;
      chk("pre_rst_fail", fail_count, model_fails);
    end

    // Bounce 1,0,1 then stable 1 -> one press; code change while held -> none
    sp = n_press;
    btn_raw = 4'b0001; tick(1);
    btn_raw = 4'b0000; tick(1);
    btn_raw = 4'b0001; tick(6);
    btn_raw = 4'b0000; tick(6);
    chk("bounce_cnt", n_press - sp, 1);
    chk("bounce_code", last_code, 4'b0001);
    sp = n_press;
    btn_raw = 4'b0011; tick(5);
    btn_raw = 4'b0001; tick(5);
    btn_raw = 4'b0000; tick(6);
    chk("change_cnt", n_press - sp, 1);
    chk("change_code", last_code, 4'b0011);

    // Reset mid-ENTRY with a button held
    btn_raw = 4'b0100; tick(1);
    rst = 1'b1; tick(1);
    chk("midrst_btn_out", btn_out, 0);
    chk("midrst_relock", relock_req, 0);
    chk("midrst_fail", fail_count, 0);
    chk("midrst_alarm", alarm, 0);
    rst = 1'b0;
    sp = n_press;
    tick(10);
    btn_raw = 4'b0000; tick(6);
    chk("held_no_press", n_press - sp, 0);
    press_btn(4'b0100, 5, 6);
    chk("repress_cnt", n_press - sp, 1);
    chk("repress_code", last_code, 4'b0100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
